nfc_ask_tx_gen: RTL and testbench
=================================

// Module: nfc_ask_tx_gen
// PURPOSE
//   Data-driven NFC transmit stimulus generator. Successor to the fixed 50% PWM ASK source: a square carrier
//   from a phase accumulator, amplitude-keyed per bit from a buffered bit stream (NRZ or Manchester),
//   framed SOF/DATA/EOF. Output v_tx is signed fixed-point and feeds the nfc channel model in emulation.
// PARAMETERS
//   AMP_W       16          width of v_tx, signed Q(AMP_W-13).12, 1.0 V = 4096
//   PHASE_W     24          carrier phase accumulator width
//   CARRIER_INC 24'h200000  phase step per clk (default = 8 clk per carrier period)
//   BIT_CYCLES  64          clk per bit period, even, >= 4
//   AMP_HI      20480       unmodulated amplitude (5.0 V)
//   AMP_LO      16384       modulated amplitude (4.0 V)
//   FIFO_DEPTH  8           bit FIFO entries, power of two
// PORTS
//   clk         in   1      emulation clock
//   rst         in   1      synchronous, active-high reset
//   en          in   1      carrier enable
//   manchester  in   1      0 = NRZ keying, 1 = Manchester keying; sampled at SOF entry only
//   in_bit      in   1      data bit
//   in_last     in   1      marks final bit of frame
//   in_valid    in   1      producer handshake
//   in_ready    out  1      = FIFO not full
//   v_tx        out  AMP_W  carrier voltage, +/-amplitude
//   tx_mod      out  1      1 while amplitude = AMP_LO
//   busy        out  1      FSM not IDLE
//   frame_done  out  1      1-clk pulse on EOF->IDLE
//   underrun    out  1      1-clk pulse when FIFO is empty at a DATA bit boundary
// BEHAVIOUR
//   Reset: v_tx=0, tx_mod=0, busy=0, frame_done=0, underrun=0, in_ready=1, phase=0, FIFO empty, FSM=IDLE.
//   Push when in_valid&in_ready; {in_last,in_bit} are stored together. Pop happens at each DATA bit boundary.
//   Simultaneous push and pop on a full FIFO: the pop frees space, but in_ready still shows full that cycle,
//     so no push is accepted then.
//   Carrier: when en=1, phase += CARRIER_INC each clk and wraps mod 2^PHASE_W. sign = phase[MSB].
//     v_tx = sign ? -amp : +amp. en=0 -> phase=0 and v_tx=0 next clk.
//   Output registered: v_tx/tx_mod reflect amp/phase of the previous clk (1-clk latency).
//   FSM (bit counter 0..BIT_CYCLES-1; each state lasts exactly one bit period):
//     IDLE: amp=AMP_HI. Enter SOF when en=1 and FIFO is non-empty; the bit counter clears.
//     SOF:  amp=AMP_LO for one bit period; latch manchester. Then DATA, popping the first bit.
//     DATA: NRZ: bit 0 -> AMP_LO, bit 1 -> AMP_HI for the full period.
//           Manchester: first half uses ~bit keying, second half uses bit keying (half = BIT_CYCLES/2).
//           At period end: if the current bit had last=1 -> EOF; else if FIFO is empty -> pulse underrun
//           and go to EOF; else pop the next bit.
//     EOF:  amp=AMP_HI for one bit period, then IDLE with a frame_done pulse.
//   en falling mid-frame: abort to IDLE next clk, flush FIFO, no frame_done. rst mid-frame is equivalent
//     to the reset state.
//   Arithmetic: negation is two's-complement at AMP_W. AMP_HI/AMP_LO are bounded to < 2^(AMP_W-1).
//     Elaboration fails if BIT_CYCLES is odd or FIFO_DEPTH is not a power of two.
// STRUCTURE
//   Package nfc_tx_pkg: tx_state_t {IDLE,SOF,DATA,EOF}; VOLT_SCALE=4096; fifo_entry_t {last,bit}.
//   Sub-module nfc_tx_fifo (synchronous FIFO, count-based full/empty). FSM, bit counter, NCO and
//     output register live in the top level.
// TESTING
//   1 en=1, FIFO empty, 100 clk -> busy=0, v_tx toggles +20480/-20480 every 4 clk, tx_mod=0.
//   2 NRZ frame 1,0,1(last) -> SOF 64 clk at +/-16384; bits HI,LO,HI for 64 clk each; EOF 64 clk HI;
//     frame_done 1 clk later; total busy = 320 clk.
//   3 Manchester, bit 1(last) -> data period: 32 clk LO then 32 clk HI; tx_mod shows 1 then 0.
//   4 Push 2 bits with no last -> after the 2nd bit: underrun pulse, EOF, frame_done; FIFO empty.
//   5 Push 9 bits back-to-back with FSM held off (en=0 then en=1) -> in_ready=0 after 8 pushes;
//     the 9th push is held until the first pop.
//   6 en=0 at clk 100 of DATA -> v_tx=0 and busy=0 next clk, FIFO empty, no frame_done; rst mid-SOF
//     gives the same result.

Source files
------------

// File: rtl/nfc_ask_tx_gen_pkg.sv
// Shared types and constants for the NFC ASK transmit generator.
package nfc_tx_pkg;

  // One ADC/DAC volt in Q.12 fixed point
  localparam int VOLT_SCALE = 4096;

  typedef enum logic [1:0] {
    IDLE,
    SOF,
    DATA,
    EOF
  } tx_state_t;

  // A queued data bit together with its end-of-frame marker
  typedef struct packed {
    logic last;
    logic dbit;
  } fifo_entry_t;

endpackage

// File: rtl/nfc_ask_tx_gen_if.sv
// Producer-side bit stream handshake for the NFC ASK transmit generator.
interface nfc_ask_tx_gen_if;

  logic in_bit;
  logic in_last;
  logic in_valid;
  logic in_ready;

  modport master (
    output in_bit,
    output in_last,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_bit,
    input  in_last,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/nfc_ask_tx_gen_fifo.sv
// Small synchronous bit FIFO with count-based full/empty and a flush input.
module nfc_tx_fifo
  import nfc_tx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        push_i,
  input  fifo_entry_t wdata_i,
  input  logic        pop_i,
  output fifo_entry_t rdata_o,
  output logic        empty_o,
  output logic        full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q;
  logic [AW-1:0] rdPtr_q;
  logic [AW:0]   count_q;
  logic          doPush;
  logic          doPop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign rdata_o = mem_q[rdPtr_q];

  // Storage array; contents need no reset because count gates every read
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy; a flush empties the queue like a reset
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/nfc_ask_tx_gen.sv
// NFC ASK transmit generator: square carrier from a phase accumulator,
// amplitude keyed per bit (NRZ or Manchester) and framed SOF/DATA/EOF.
module nfc_ask_tx_gen
  import nfc_tx_pkg::*;
#(
  parameter int                 AMP_W       = 16,
  parameter int                 PHASE_W     = 24,
  parameter logic [PHASE_W-1:0] CARRIER_INC = PHASE_W'(24'h200000),
  parameter int                 BIT_CYCLES  = 64,
  parameter int                 AMP_HI      = 5 * VOLT_SCALE,
  parameter int                 AMP_LO      = 4 * VOLT_SCALE,
  parameter int                 FIFO_DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    manchester_i,
  nfc_ask_tx_gen_if.slave         bus_if,
  output logic signed [AMP_W-1:0] v_tx_o,
  output logic                    tx_mod_o,
  output logic                    busy_o,
  output logic                    frame_done_o,
  output logic                    underrun_o
);

  if ((BIT_CYCLES % 2) != 0 || BIT_CYCLES < 4) begin : g_chk_bit_cycles
    $error("BIT_CYCLES must be even and at least 4");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_fifo_depth
    $error("FIFO_DEPTH must be a power of two");
  end
  if (AMP_HI < 0 || AMP_LO < 0 || AMP_HI >= 2**(AMP_W-1) || AMP_LO >= 2**(AMP_W-1)) begin : g_chk_amp
    $error("AMP_HI/AMP_LO must fit in the positive range of v_tx");
  end

  localparam int                       CNT_W    = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]         HALF_CNT = CNT_W'(BIT_CYCLES / 2);
  localparam logic signed [AMP_W-1:0]  AMP_HI_V = AMP_W'(AMP_HI);
  localparam logic signed [AMP_W-1:0]  AMP_LO_V = AMP_W'(AMP_LO);

  tx_state_t                state_q;
  logic [CNT_W-1:0]         bitCnt_q;
  fifo_entry_t              curBit_q;
  logic                     manch_q;
  logic                     frameDone_q;
  logic                     underrun_q;
  logic [PHASE_W-1:0]       phase_q;
  logic [PHASE_W-1:0]       phase_d;
  logic signed [AMP_W-1:0]  vTx_q;
  logic signed [AMP_W-1:0]  vTx_d;
  logic                     txMod_q;
  logic                     txMod_d;

  fifo_entry_t              fifoHead;
  fifo_entry_t              fifoWdata;
  logic                     fifoEmpty;
  logic                     fifoFull;
  logic                     fifoPush;
  logic                     fifoPop;
  logic                     fifoFlush;
  logic                     bitEnd;
  logic                     keyHi;
  logic signed [AMP_W-1:0]  ampSel;

  assign bus_if.in_ready = ~fifoFull;
  assign fifoPush        = bus_if.in_valid & ~fifoFull;
  assign fifoWdata       = {bus_if.in_last, bus_if.in_bit};
  assign bitEnd          = (bitCnt_q == LAST_CNT);
  assign fifoPop         = en_i && bitEnd &&
                           ((state_q == SOF) ||
                            (state_q == DATA && !curBit_q.last && !fifoEmpty));
  assign fifoFlush       = !en_i && (state_q != IDLE);

  assign v_tx_o       = vTx_q;
  assign tx_mod_o     = txMod_q;
  assign busy_o       = (state_q != IDLE);
  assign frame_done_o = frameDone_q;
  assign underrun_o   = underrun_q;

  nfc_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (fifoFlush),
    .push_i  (fifoPush),
    .wdata_i (fifoWdata),
    .pop_i   (fifoPop),
    .rdata_o (fifoHead),
    .empty_o (fifoEmpty),
    .full_o  (fifoFull)
  );

  // Amplitude keying for the current state; Manchester inverts the first half-bit
  always_comb begin
    keyHi = 1'b1;
    case (state_q)
      IDLE: keyHi = 1'b1;
      SOF:  keyHi = 1'b0;
      DATA: begin
        if (manch_q && (bitCnt_q < HALF_CNT)) begin
          keyHi = ~curBit_q.dbit;
        end else begin
          keyHi = curBit_q.dbit;
        end
      end
      EOF:  keyHi = 1'b1;
      default: keyHi = 1'b1;
    endcase
    ampSel = keyHi ? AMP_HI_V : AMP_LO_V;
  end

  // Carrier next state: phase advances while enabled, sign of phase picks +/-amp
  always_comb begin
    phase_d = '0;
    vTx_d   = '0;
    txMod_d = 1'b0;
    if (en_i) begin
      phase_d = phase_q + CARRIER_INC;
      vTx_d   = phase_q[PHASE_W-1] ? -ampSel : ampSel;
      txMod_d = ~keyHi;
    end
  end

  // Carrier phase and registered output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      vTx_q   <= '0;
      txMod_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      vTx_q   <= vTx_d;
      txMod_q <= txMod_d;
    end
  end

  // Frame sequencer: one bit period per SOF/DATA/EOF step, aborts when en drops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bitCnt_q    <= '0;
      curBit_q    <= '0;
      manch_q     <= 1'b0;
      frameDone_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      frameDone_q <= 1'b0;
      underrun_q  <= 1'b0;
      if (!en_i) begin
        state_q  <= IDLE;
        bitCnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (!fifoEmpty) begin
              state_q  <= SOF;
              bitCnt_q <= '0;
              manch_q  <= manchester_i;
            end
          end
          SOF: begin
            if (bitEnd) begin
              state_q  <= DATA;
              bitCnt_q <= '0;
              curBit_q <= fifoHead;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
          DATA: begin
            if (bitEnd) begin
              bitCnt_q <= '0;
              if (curBit_q.last) begin
                state_q <= EOF;
              end else if (fifoEmpty) begin
                state_q    <= EOF;
                underrun_q <= 1'b1;
              end else begin
                curBit_q <= fifoHead;
              end
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
          EOF: begin
            if (bitEnd) begin
              state_q     <= IDLE;
              bitCnt_q    <= '0;
              frameDone_q <= 1'b1;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
            end
          end
          default: begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nfc_ask_tx_gen.sv
// Self-checking bench for nfc_ask_tx_gen: table of frames plus hand-written
// corner sequences, with per-cycle expectations held in a scoreboard queue.
module tb_nfc_ask_tx_gen;

  localparam int AMP_HI = 20480;
  localparam int AMP_LO = 16384;
  localparam int BITC   = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               manchester;
  logic signed [15:0] vTx;
  logic               txMod;
  logic               busy;
  logic               frameDone;
  logic               underrun;

  nfc_ask_tx_gen_if bus();

  nfc_ask_tx_gen dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .manchester_i (manchester),
    .bus_if       (bus),
    .v_tx_o       (vTx),
    .tx_mod_o     (txMod),
    .busy_o       (busy),
    .frame_done_o (frameDone),
    .underrun_o   (underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   amp;
    logic busy;
    logic frameDone;
    logic underrun;
    logic ready;
  } exp_t;

  typedef struct {
    logic       man;
    int         nbits;
    logic [8:0] bits;
    logic       hasLast;
    int         expBusy;
    logic       expUnderrun;
  } frame_vec_t;

  exp_t       sbQueue[$];
  frame_vec_t vecs[5];
  int         assertCount = 0;
  int         failCount   = 0;
  int         busyCount;
  int         underrunCount;
  int         acceptedAt;

  task automatic checkOutput(input string name, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Carrier sign for the i-th sample after en rises from a zeroed phase
  function automatic logic expSign(input int i);
    logic [23:0] ph;
    ph = 24'(longint'(i) * 64'h20_0000);
    return ph[23];
  endfunction

  function automatic int bitAmp(input logic man, input logic b, input int j);
    logic hi;
    hi = man ? ((j <= BITC/2) ? ~b : b) : b;
    return hi ? AMP_HI : AMP_LO;
  endfunction

  // Push a frame's worth of per-sample expectations onto the scoreboard
  task automatic buildExpected(input frame_vec_t v, input logic fill9);
    int total;
    exp_t e;
    int k;
    total = BITC * (v.nbits + 2) + 4;
    for (int i = 0; i < total; i++) begin
      k = (i - 1) / BITC;
      if (i == 0)                      e.amp = AMP_HI;
      else if (i <= BITC)              e.amp = AMP_LO;
      else if (k >= 1 && k <= v.nbits) e.amp = bitAmp(v.man, v.bits[k-1], i - BITC*k);
      else                             e.amp = AMP_HI;
      e.busy      = (i < BITC * (v.nbits + 2));
      e.frameDone = (i == BITC * (v.nbits + 2));
      e.underrun  = !v.hasLast && (i == BITC * (v.nbits + 1));
      if (fill9) e.ready = (i == BITC) || (i >= 2*BITC);
      else       e.ready = 1'b1;
      sbQueue.push_back(e);
    end
  endtask

  task automatic buildIdle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.amp = AMP_HI; e.busy = 1'b0; e.frameDone = 1'b0; e.underrun = 1'b0; e.ready = 1'b1;
      sbQueue.push_back(e);
    end
  endtask

  // Pop and compare one expectation per clock; en is assumed to rise just before
  task automatic runScoreboard(input string name, input int maxSamples);
    exp_t e;
    logic acceptNext;
    logic signed [31:0] ev;
    busyCount = 0;
    underrunCount = 0;
    for (int i = 0; i < maxSamples && sbQueue.size() > 0; i++) begin
      acceptNext = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acceptNext) begin
        bus.in_valid = 1'b0;
        acceptedAt = i;
      end
      if (i == 10) manchester = ~manchester;
      e = sbQueue.pop_front();
      ev = expSign(i) ? -e.amp : e.amp;
      checkOutput($sformatf("%s[%0d].v_tx", name, i), vTx, ev);
      checkOutput($sformatf("%s[%0d].tx_mod", name, i), txMod, (e.amp == AMP_LO));
      checkOutput($sformatf("%s[%0d].busy", name, i), busy, e.busy);
      checkOutput($sformatf("%s[%0d].frame_done", name, i), frameDone, e.frameDone);
      checkOutput($sformatf("%s[%0d].underrun", name, i), underrun, e.underrun);
      checkOutput($sformatf("%s[%0d].in_ready", name, i), bus.in_ready, e.ready);
      if (busy === 1'b1) busyCount++;
      if (underrun === 1'b1) underrunCount++;
    end
  endtask

  task automatic applyStimulus(input logic b, input logic l);
    int guard;
    guard = 0;
    bus.in_bit   = b;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) checkOutput("push_accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic settle();
    en = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkStaysIdle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s[%0d].busy", name, i), busy, 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int doneSeen;
    vecs[0] = '{man: 1'b0, nbits: 3, bits: 9'b000000101, hasLast: 1'b1, expBusy: 320, expUnderrun: 1'b0};
    vecs[1] = '{man: 1'b1, nbits: 1, bits: 9'b000000001, hasLast: 1'b1, expBusy: 192, expUnderrun: 1'b0};
    vecs[2] = '{man: 1'b0, nbits: 2, bits: 9'b000000011, hasLast: 1'b0, expBusy: 256, expUnderrun: 1'b1};
    vecs[3] = '{man: 1'b1, nbits: 4, bits: 9'b000000110, hasLast: 1'b1, expBusy: 384, expUnderrun: 1'b0};
    vecs[4] = '{man: 1'b0, nbits: 1, bits: 9'b000000000, hasLast: 1'b1, expBusy: 192, expUnderrun: 1'b0};

    rst = 1'b1;
    en = 1'b0;
    manchester = 1'b0;
    bus.in_bit = 1'b0;
    bus.in_last = 1'b0;
    bus.in_valid = 1'b0;
    acceptedAt = -1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("reset.v_tx", vTx, 0);
    checkOutput("reset.tx_mod", txMod, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.frame_done", frameDone, 0);
    checkOutput("reset.underrun", underrun, 0);
    checkOutput("reset.in_ready", bus.in_ready, 1);
    rst = 1'b0;
    settle();

    $display("[TB] idle carrier, empty FIFO");
    buildIdle(100);
    en = 1'b1;
    runScoreboard("idle", 100);
    settle();

    for (int v = 0; v < 5; v++) begin
      $display("[TB] frame vector %0d", v);
      for (int k = 0; k < vecs[v].nbits; k++) begin
        applyStimulus(vecs[v].bits[k], vecs[v].hasLast && (k == vecs[v].nbits - 1));
      end
      manchester = vecs[v].man;
      buildExpected(vecs[v], 1'b0);
      en = 1'b1;
      runScoreboard($sformatf("vec%0d", v), 1000);
      checkOutput($sformatf("vec%0d.busy_cycles", v), busyCount, vecs[v].expBusy);
      checkOutput($sformatf("vec%0d.underrun_pulses", v), underrunCount, vecs[v].expUnderrun);
      settle();
    end

    $display("[TB] FIFO fill and back-pressure");
    begin
      frame_vec_t fv;
      fv = '{man: 1'b0, nbits: 9, bits: 9'b101101001, hasLast: 1'b1, expBusy: 704, expUnderrun: 1'b0};
      for (int k = 0; k < 8; k++) applyStimulus(fv.bits[k], 1'b0);
      checkOutput("fill.in_ready_after_8", bus.in_ready, 0);
      bus.in_bit = fv.bits[8];
      bus.in_last = 1'b1;
      bus.in_valid = 1'b1;
      acceptedAt = -1;
      manchester = 1'b0;
      buildExpected(fv, 1'b1);
      en = 1'b1;
      runScoreboard("fill", 1000);
      checkOutput("fill.ninth_accept_sample", acceptedAt, BITC + 1);
      checkOutput("fill.busy_cycles", busyCount, fv.expBusy);
      settle();
    end

    $display("[TB] en drop mid DATA");
    begin
      frame_vec_t av;
      av = '{man: 1'b0, nbits: 4, bits: 9'b000001001, hasLast: 1'b1, expBusy: 384, expUnderrun: 1'b0};
      for (int k = 0; k < 4; k++) applyStimulus(av.bits[k], k == 3);
      manchester = 1'b0;
      buildExpected(av, 1'b0);
      en = 1'b1;
      runScoreboard("abort", BITC + 100);
      sbQueue.delete();
      en = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("abort.v_tx", vTx, 0);
      checkOutput("abort.tx_mod", txMod, 0);
      checkOutput("abort.busy", busy, 0);
      checkOutput("abort.frame_done", frameDone, 0);
      doneSeen = 0;
      for (int i = 0; i < 70; i++) begin
        @(posedge clk);
        #1;
        if (frameDone === 1'b1) doneSeen++;
      end
      checkOutput("abort.frame_done_pulses", doneSeen, 0);
      en = 1'b1;
      checkStaysIdle("abort_flushed", 6);
      settle();
    end

    $display("[TB] rst mid SOF");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1);
    en = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checkOutput("rst_sof.busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_sof.v_tx", vTx, 0);
    checkOutput("rst_sof.tx_mod", txMod, 0);
    checkOutput("rst_sof.busy", busy, 0);
    checkOutput("rst_sof.frame_done", frameDone, 0);
    checkOutput("rst_sof.underrun", underrun, 0);
    checkOutput("rst_sof.in_ready", bus.in_ready, 1);
    rst = 1'b0;
    checkStaysIdle("rst_flushed", 6);
    settle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
